// File: rtl/tm1637_pkg.sv
// Shared types and constants for the tm1637 byte-engine arbiter.
// Command bytes are the ones requesters typically send to start a display update.
package tm1637_pkg;
  localparam int NUM_REQ_DEFAULT = 2;
  localparam int TIMEOUT_DEFAULT = 255;

  localparam logic [7:0] CMD_DATA_MODE  = 8'h40;
  localparam logic [7:0] CMD_ADDR       = 8'hC0;
  localparam logic [7:0] CMD_DISPLAY_ON = 8'h8F;

  typedef enum logic [2:0] {
    IDLE,
    GRANTED,
    ISSUE,
    RELEASE_LATCH,
    WAIT_DONE
  } arb_state_e;
endpackage

// File: rtl/tm1637_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after index 'last', wrapping.
module rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  input  logic [1:0]   last,
  output logic [N-1:0] winner,
  output logic         valid
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  int idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      if (!valid && req[idx[IW-1:0]]) begin
        winner[idx[IW-1:0]] = 1'b1;
        valid               = 1'b1;
      end
    end
  end
endmodule

// File: rtl/tm1637_arbiter.sv
// Shares one tm1637 byte engine between NUM_REQ requesters, one whole transaction per grant.
// states: IDLE wait req | GRANTED owner may offer byte | ISSUE latch pulse | RELEASE_LATCH busy rises | WAIT_DONE engine busy
module tm1637_arbiter
  import tm1637_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  output logic [NUM_REQ-1:0]   gnt,
  input  logic [NUM_REQ-1:0]   byte_valid,
  input  logic [8*NUM_REQ-1:0] byte_data,
  input  logic [NUM_REQ-1:0]   byte_stop,
  output logic [NUM_REQ-1:0]   byte_ready,
  output logic                 abort,
  output logic                 tm_latch,
  output logic [7:0]           tm_byte,
  output logic                 tm_stop_bit,
  input  logic                 tm_busy
);
  localparam int CW = $clog2(TIMEOUT + 1);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [1:0]         last_q, last_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               latch_q, latch_d;
  logic               ready_q, ready_d;
  logic               abort_q, abort_d;
  logic [7:0]         byte_q, byte_d;
  logic               stop_q, stop_d;

  logic [NUM_REQ-1:0] winner;
  logic               win_valid;
  logic [1:0]         win_idx;
  logic               sel_req, sel_valid, sel_stop;
  logic [7:0]         sel_data;

  rr_pick #(.N(NUM_REQ)) u_rr_pick (
    .req    (req),
    .last   (last_q),
    .winner (winner),
    .valid  (win_valid)
  );

  always_comb begin
    win_idx = last_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner[i]) win_idx = 2'(i);
    end
  end

  // Only the granted requester's lines are visible to the FSM.
  always_comb begin
    sel_req   = 1'b0;
    sel_valid = 1'b0;
    sel_stop  = 1'b0;
    sel_data  = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_q[i]) begin
        sel_req   = req[i];
        sel_valid = byte_valid[i];
        sel_stop  = byte_stop[i];
        sel_data  = byte_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    latch_d = 1'b0;
    ready_d = 1'b0;
    abort_d = 1'b0;
    byte_d  = byte_q;
    stop_d  = stop_q;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          gnt_d   = winner;
          last_d  = win_idx;
          cnt_d   = '0;
          state_d = GRANTED;
        end
      end
      GRANTED: begin
        if (!sel_req) begin
          gnt_d   = '0;
          abort_d = 1'b1;
          state_d = IDLE;
        end else if (sel_valid) begin
          if (!tm_busy) begin
            byte_d  = sel_data;
            stop_d  = sel_stop;
            latch_d = 1'b1;
            ready_d = 1'b1;
            cnt_d   = '0;
            state_d = ISSUE;
          end
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          gnt_d   = '0;
          abort_d = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ISSUE:         state_d = RELEASE_LATCH;
      RELEASE_LATCH: state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (!tm_busy) begin
          if (stop_q) begin
            gnt_d   = '0;
            state_d = IDLE;
          end else begin
            state_d = GRANTED;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= 2'(NUM_REQ - 1);
      cnt_q   <= '0;
      latch_q <= 1'b0;
      ready_q <= 1'b0;
      abort_q <= 1'b0;
      byte_q  <= 8'h00;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      latch_q <= latch_d;
      ready_q <= ready_d;
      abort_q <= abort_d;
      byte_q  <= byte_d;
      stop_q  <= stop_d;
    end
  end

  assign gnt         = gnt_q;
  assign byte_ready  = {NUM_REQ{ready_q}} & gnt_q;
  assign abort       = abort_q;
  assign tm_latch    = latch_q;
  assign tm_byte     = byte_q;
  assign tm_stop_bit = stop_q;
endmodule

// File: tb/tb_tm1637_arbiter.sv
// Directed and randomized bench for tm1637_arbiter against a transaction-level model
// (round-robin over requesters that still have bytes queued) plus a simple engine model.
module tb_tm1637_arbiter;
  localparam int NR = 2;
  localparam int TO = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req;
  logic [NR-1:0]     gnt;
  logic [NR-1:0]     byte_valid;
  logic [8*NR-1:0]   byte_data;
  logic [NR-1:0]     byte_stop;
  logic [NR-1:0]     byte_ready;
  logic              abort;
  logic              tm_latch;
  logic [7:0]        tm_byte;
  logic              tm_stop_bit;
  logic              tm_busy;

  int n_pass  = 0;
  int n_total = 0;

  int busy_left = 0;
  int busy_fix  = 0;
  int latch_cnt = 0;
  int model_last;
  logic [7:0]    txq [NR][$];
  int            gap_left [NR];
  logic [NR-1:0] g_prev, g_hist;
  logic          prev_latch;

  always #5 clk = ~clk;

  tm1637_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .gnt         (gnt),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .byte_stop   (byte_stop),
    .byte_ready  (byte_ready),
    .abort       (abort),
    .tm_latch    (tm_latch),
    .tm_byte     (tm_byte),
    .tm_stop_bit (tm_stop_bit),
    .tm_busy     (tm_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int model_pick(input logic [NR-1:0] pend, input int last);
    for (int k = 1; k <= NR; k++) begin
      if (pend[(last + k) % NR]) return (last + k) % NR;
    end
    return -1;
  endfunction

  // One clock: engine model reacts to tm_latch, then per-cycle invariants are checked.
  task automatic tick();
    @(posedge clk);
    #1;
    if (tm_latch) busy_left = (busy_fix > 0) ? busy_fix : int'($urandom_range(1, 4));
    else if (busy_left > 0) busy_left--;
    tm_busy = (busy_left > 0);
    if (tm_latch) latch_cnt++;
    g_prev = g_hist;
    chk("ready_vs_latch", 32'(byte_ready), tm_latch ? 32'(gnt) : 32'd0);
    if (prev_latch) chk("latch_one_cycle", 32'(tm_latch), 32'd0);
    if (g_prev != 0 && gnt != 0) chk("gnt_stable", 32'(gnt), 32'(g_prev));
    g_hist     = gnt;
    prev_latch = tm_latch;
  endtask

  task automatic check_reset(input string p);
    chk({p, "_gnt"},        32'(gnt),         32'd0);
    chk({p, "_byte_ready"}, 32'(byte_ready),  32'd0);
    chk({p, "_abort"},      32'(abort),       32'd0);
    chk({p, "_tm_latch"},   32'(tm_latch),    32'd0);
    chk({p, "_tm_byte"},    32'(tm_byte),     32'd0);
    chk({p, "_tm_stop"},    32'(tm_stop_bit), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; byte_valid = '0; byte_stop = '0; byte_data = '0;
    tick();
    tick();
    rst = 1'b0; busy_left = 0; tm_busy = 1'b0;
    model_last = NR - 1;
  endtask

  // Owner offers its queue front after a random short gap; others drive noise.
  task automatic drive();
    for (int r = 0; r < NR; r++) begin
      if (gnt[r] && txq[r].size() > 0) begin
        if (gap_left[r] > 0) begin
          gap_left[r]--;
          byte_valid[r] = 1'b0;
        end else begin
          byte_valid[r]         = 1'b1;
          byte_data[8*r +: 8]   = txq[r][0];
          byte_stop[r]          = (txq[r].size() == 1);
        end
      end else if (!gnt[r]) begin
        byte_valid[r]       = 1'($urandom);
        byte_data[8*r +: 8] = 8'($urandom);
        byte_stop[r]        = 1'($urandom);
      end else begin
        byte_valid[r] = 1'b0;
      end
    end
  endtask

  task automatic run_txns(input logic [NR-1:0] mask);
    logic [NR-1:0] pending;
    logic [7:0]    dummy;
    int owner, exp_total;
    bit done;
    pending = mask; owner = -1; exp_total = 0; done = 0; latch_cnt = 0;
    for (int r = 0; r < NR; r++) begin
      exp_total  += txq[r].size();
      gap_left[r] = int'($urandom_range(0, 2));
    end
    req = mask;
    drive();
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      tick();
      if (cyc == 0) chk("grant_latency", 32'(gnt != 0), 32'd1);
      if (gnt != 0 && g_prev == 0) begin
        owner = model_pick(pending, model_last);
        chk("grant_owner", 32'(gnt), (owner >= 0) ? (32'd1 << owner) : 32'd0);
        if (owner >= 0) model_last = owner;
      end
      if (abort) chk("unexpected_abort", 32'(abort), 32'd0);
      if (byte_ready != 0) begin
        if (owner >= 0 && txq[owner].size() > 0) begin
          chk("byte_data", 32'(tm_byte), 32'(txq[owner][0]));
          chk("byte_stop", 32'(tm_stop_bit), 32'(txq[owner].size() == 1));
          dummy = txq[owner].pop_front();
          if (txq[owner].size() == 0) begin
            pending[owner] = 1'b0;
            req[owner]     = 1'b0;
          end else begin
            gap_left[owner] = int'($urandom_range(0, 2));
          end
        end else begin
          chk("spurious_ready", 32'(byte_ready), 32'd0);
        end
      end
      if (pending == 0 && gnt == 0) done = 1;
      drive();
    end
    chk("round_done", 32'(done), 32'd1);
    chk("latch_count", 32'(latch_cnt), 32'(exp_total));
  endtask

  initial begin
    logic [NR-1:0] m;
    int gcnt;
    bit seen;
    rst = 1'b1; req = '0; byte_valid = '0; byte_data = '0; byte_stop = '0; tm_busy = 1'b0;
    g_prev = '0; g_hist = '0; prev_latch = 1'b0;

    do_reset();
    check_reset("reset");

    // single requester, one stop byte
    txq[0].push_back(8'h40);
    run_txns(2'b01);

    // contention from reset: 0 first, then 1; next contention 0 again
    do_reset();
    txq[0].push_back(8'hC0); txq[0].push_back(8'h3F);
    txq[1].push_back(8'hC0); txq[1].push_back(8'h3F);
    run_txns(2'b11);
    txq[0].push_back(8'hC0); txq[0].push_back(8'h3F);
    txq[1].push_back(8'hC0); txq[1].push_back(8'h3F);
    run_txns(2'b11);

    // multi-byte from requester 1
    txq[1].push_back(8'hC0); txq[1].push_back(8'h06); txq[1].push_back(8'h5B);
    txq[1].push_back(8'h4F); txq[1].push_back(8'h66);
    run_txns(2'b10);

    // idle timeout; requester 1 waves byte_valid without a request
    req = 2'b01; byte_valid = 2'b10; byte_stop = '0;
    gcnt = 0; seen = 0; latch_cnt = 0;
    for (int cyc = 0; cyc < 40 && !seen; cyc++) begin
      tick();
      if (abort) begin
        seen = 1;
        chk("timeout_gnt_drop", 32'(gnt), 32'd0);
        req = '0;
      end else if (gnt[0]) begin
        gcnt++;
      end
    end
    chk("timeout_abort", 32'(seen), 32'd1);
    chk("timeout_cycles", 32'(gcnt), 32'(TO));
    chk("timeout_no_latch", 32'(latch_cnt), 32'd0);
    model_last = 0;
    byte_valid = '0;
    tick();
    chk("timeout_abort_pulse", 32'(abort), 32'd0);

    // request withdrawn while granted
    req = 2'b01;
    tick();
    chk("drop_grant", 32'(gnt), 32'd1);
    tick();
    req = '0;
    tick();
    chk("drop_abort", 32'(abort), 32'd1);
    chk("drop_gnt", 32'(gnt), 32'd0);
    tick();
    chk("drop_abort_pulse", 32'(abort), 32'd0);
    model_last = 0;

    // randomized rounds
    for (int rnd = 0; rnd < 30; rnd++) begin
      m = NR'($urandom_range(1, (1 << NR) - 1));
      for (int r = 0; r < NR; r++) begin
        if (m[r]) begin
          for (int b = int'($urandom_range(1, 4)); b > 0; b--) txq[r].push_back(8'($urandom));
        end
      end
      run_txns(m);
    end

    // reset while the engine is busy with a non-stop byte
    busy_fix = 4;
    req = 2'b01; byte_valid = '0;
    tick();
    chk("wd_grant", 32'(gnt), 32'd1);
    byte_valid = 2'b01; byte_data[7:0] = 8'h12; byte_stop = '0;
    tick();
    chk("wd_latch", 32'(tm_latch), 32'd1);
    chk("wd_byte", 32'(tm_byte), 32'h12);
    byte_valid = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_reset("wd_reset");
    rst = 1'b0; req = '0; busy_left = 0; tm_busy = 1'b0; busy_fix = 0;
    tick();
    chk("wd_no_abort", 32'(abort), 32'd0);
    chk("wd_gnt_idle", 32'(gnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
